// File: rtl/fetch1_rs1_arb_pkg.sv
// Shared fetch definitions: rs1 arbiter state encoding, RAS/branch type codes and
// architectural width constants.
package fetch1_rs1_arb_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned REGIDX_W = 5;

  // rs1 arbiter sequencing states
  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } rs1_state_e;

  // Return-address-stack action codes
  localparam int unsigned RAS_DEPTH   = 8;
  localparam logic [1:0]  RAS_NONE    = 2'd0;
  localparam logic [1:0]  RAS_PUSH    = 2'd1;
  localparam logic [1:0]  RAS_POP     = 2'd2;
  localparam logic [1:0]  RAS_POPPUSH = 2'd3;

  // Branch decoder classification codes
  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_JAL  = 2'd2;
  localparam logic [1:0] BR_JALR = 2'd3;

  // x1 and x5 are the link registers that drive RAS push/pop hints
  function automatic logic is_link_reg(logic [REGIDX_W-1:0] idx);
    return (idx == 5'd1) || (idx == 5'd5);
  endfunction

endpackage

// File: rtl/fetch1_rs1_arb_prio_enc_first.sv
// Lowest-set-bit priority encoder; also used by fetch bundle-termination logic.
module prio_enc_first #(
  parameter int unsigned Width = 8,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             found_o
);

  // Scan upward; the first set bit wins
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < Width; i++) begin
      if (req_i[i] && !found_o) begin
        found_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/fetch1_rs1_arb.sv
// Fetch-1 scheduler for the shared integer RF read port used by JALR targets.
// Optional write-back bypass enabled by defining RS1_WB_BYPASS_EN.
module fetch1_rs1_arb
  import fetch1_rs1_arb_pkg::*;
#(
  parameter int unsigned NWAY     = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     fetch_vld_i,
  input  logic                     flush_i,
  input  logic [NWAY-1:0]          way_req_i,
  input  logic [NWAY*REGIDX_W-1:0] way_idx_i,
  output logic                     rf_rd_req_o,
  output logic [REGIDX_W-1:0]      rf_rd_idx_o,
  input  logic                     rf_rd_gnt_i,
  input  logic [XLEN-1:0]          rf_rd_data_i,
`ifdef RS1_WB_BYPASS_EN
  input  logic                     wb_vld_i,
  input  logic [REGIDX_W-1:0]      wb_idx_i,
  input  logic [XLEN-1:0]          wb_data_i,
`endif
  output logic [NWAY-1:0]          rs1_vld_o,
  output logic [XLEN-1:0]          rs1_data_o,
  output logic                     rs1_fail_o,
  output logic                     f1_stall_o
);

  localparam int unsigned SelW    = (NWAY > 1) ? $clog2(NWAY) : 1;
  localparam logic [1:0]  LatInit = 2'(RD_LAT - 1);
  localparam logic [7:0]  WaitMax = 8'(MAX_WAIT - 1);

  rs1_state_e          state_q, state_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [REGIDX_W-1:0] idx_q, idx_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic                fail_q, fail_d;
  logic                req_q, req_d;

  logic [SelW-1:0]     enc_idx;
  logic                enc_found;
  logic [REGIDX_W-1:0] new_idx;
  logic                wb_hit_new, wb_hit_cur;
  logic [XLEN-1:0]     wb_data;

  prio_enc_first #(
    .Width (NWAY),
    .IdxW  (SelW)
  ) u_prio_enc_first (
    .req_i   (way_req_i),
    .idx_o   (enc_idx),
    .found_o (enc_found)
  );

  assign new_idx = way_idx_i[enc_idx*REGIDX_W +: REGIDX_W];

`ifdef RS1_WB_BYPASS_EN
  assign wb_hit_new = wb_vld_i && (wb_idx_i == new_idx);
  assign wb_hit_cur = wb_vld_i && (wb_idx_i == idx_q);
  assign wb_data    = wb_data_i;
`else
  assign wb_hit_new = 1'b0;
  assign wb_hit_cur = 1'b0;
  assign wb_data    = '0;
`endif

  // Next-state sequencing; flush overrides everything at the end
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    data_d     = data_q;
    fail_d     = fail_q;
    case (state_q)
      StIdle: begin
        wait_cnt_d = '0;
        lat_cnt_d  = '0;
        fail_d     = 1'b0;
        if (fetch_vld_i && enc_found) begin
          sel_d = enc_idx;
          idx_d = new_idx;
          if (new_idx == '0) begin
            // x0 reads as zero; no port access needed
            data_d  = '0;
            state_d = StDone;
          end else if (wb_hit_new) begin
            data_d  = wb_data;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (wb_hit_cur) begin
          data_d  = wb_data;
          state_d = StDone;
        end else if (rf_rd_gnt_i) begin
          // Grant beats a coincident timeout
          lat_cnt_d = LatInit;
          state_d   = StWait;
        end else if (wait_cnt_q == WaitMax) begin
          fail_d  = 1'b1;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StWait: begin
        if (wb_hit_cur) begin
          data_d  = wb_data;
          state_d = StDone;
        end else if (lat_cnt_q == '0) begin
          data_d  = rf_rd_data_i;
          state_d = StDone;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      StDone: begin
        wait_cnt_d = '0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d    = StIdle;
      wait_cnt_d = '0;
      lat_cnt_d  = '0;
      fail_d     = 1'b0;
    end
  end

  // Port request is registered so it is glitch-free while waiting for grant
  assign req_d = (state_d == StReq);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
      data_q     <= '0;
      fail_q     <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      data_q     <= data_d;
      fail_q     <= fail_d;
      req_q      <= req_d;
    end
  end

  // Result qualification toward the ways
  always_comb begin
    rs1_vld_o = '0;
    if (state_q == StDone && !fail_q) begin
      rs1_vld_o[sel_q] = 1'b1;
    end
  end

  assign rf_rd_req_o = req_q;
  assign rf_rd_idx_o = idx_q;
  assign rs1_data_o  = data_q;
  assign rs1_fail_o  = (state_q == StDone) && fail_q;
  assign f1_stall_o  = ((state_q == StIdle) && fetch_vld_i && (|way_req_i)) ||
                       (state_q == StReq) || (state_q == StWait);

endmodule
